// File: rtl/crc_pkg.sv
// Shared CRC-32 definitions: reflected polynomial, good-packet residue,
// stream FSM state encoding and the last-beat byte counter.
package crc_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic {
    IDLE,
    ACCUM
  } crc_state_e;

  // Counts enabled bytes in a keep mask; narrower masks are zero-extended to 8 bits.
  function automatic logic [3:0] popcount_keep(input logic [7:0] keep);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, keep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/crc32_byte.sv
// One combinational step of the reflected CRC-32: folds one byte into the
// running register, LSB first.
module crc32_byte
  import crc_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC-32 over valid/ready beats with a single registered result per packet.
// Optional residue comparator on res_ok_o is built when CRC_STREAM_CHECK_EN is defined.
module crc_stream
  import crc_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF,
  parameter int          LEN_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic [DATA_W/8-1:0] s_keep_i,
  input  logic                s_last_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [31:0]         res_crc_o,
  output logic [LEN_W-1:0]    res_len_o,
  output logic                res_ok_o
);

  localparam int NB = DATA_W / 8;

  crc_state_e       state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_crc_q, res_crc_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;

  logic [31:0]      chain [NB+1];
  logic [7:0]       keep8;
  logic [3:0]       n_bytes;
  logic [31:0]      next_crc;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] next_len;
  logic             accept;

  // The result register is the only buffer, so input stalls while it is held.
  assign s_ready_o = ~res_valid_q | res_ready_i;
  assign accept    = s_valid_i & s_ready_o;

  assign chain[0] = crc_q;
  for (genvar g = 0; g < NB; g++) begin : g_byte
    crc32_byte u_byte (
      .crc_i  (chain[g]),
      .data_i (s_data_i[8*g +: 8]),
      .crc_o  (chain[g+1])
    );
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    keep8           = '0;
    keep8[NB-1:0]   = s_keep_i;
    n_bytes         = s_last_i ? popcount_keep(keep8) : 4'(NB);
    next_crc        = chain[0];
    for (int i = 1; i <= NB; i++) begin
      if (n_bytes == 4'(i)) next_crc = chain[i];
    end
    len_sum  = {1'b0, len_q} + (LEN_W+1)'(n_bytes);
    next_len = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    len_d       = len_q;
    res_valid_d = res_valid_q;
    res_crc_d   = res_crc_q;
    res_len_d   = res_len_q;
    if (res_valid_q && res_ready_i) res_valid_d = 1'b0;
    if (accept) begin
      if (s_last_i) begin
        state_d     = IDLE;
        crc_d       = INIT;
        len_d       = '0;
        res_valid_d = 1'b1;
        res_crc_d   = next_crc ^ XOROUT;
        res_len_d   = next_len;
      end else begin
        state_d = ACCUM;
        crc_d   = next_crc;
        len_d   = next_len;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      len_q       <= '0;
      res_valid_q <= 1'b0;
      res_crc_q   <= '0;
      res_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      res_valid_q <= res_valid_d;
      res_crc_q   <= res_crc_d;
      res_len_q   <= res_len_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_crc_o   = res_crc_q;
  assign res_len_o   = res_len_q;

`ifdef CRC_STREAM_CHECK_EN
  logic res_ok_q, res_ok_d;

  // The raw register lands on the fixed residue when the packet carries its own FCS.
  always_comb begin
    res_ok_d = res_ok_q;
    if (accept && s_last_i) res_ok_d = (next_crc == CRC32_RESIDUE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) res_ok_q <= 1'b0;
    else         res_ok_q <= res_ok_d;
  end

  assign res_ok_o = res_ok_q;
`else
  assign res_ok_o = 1'b0;
`endif

`ifndef SYNTHESIS
  logic [NB-1:0] keep_inc;
  assign keep_inc = s_keep_i + NB'(1);

  keep_contiguous_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (accept && s_last_i) |-> ((s_keep_i & keep_inc) == '0))
    else $error("non-contiguous s_keep_i on last beat");
`endif

endmodule

// File: tb/tb_crc_stream.sv
// Directed bench for crc_stream: a 32-bit instance for packet vectors, back-to-back
// and reset abort, and an 8-bit, LEN_W=4 instance for stall and length saturation.
module tb_crc_stream;

  logic clk;
  logic rst_n;

  logic        a_s_valid, a_s_ready, a_s_last, a_res_valid, a_res_ready, a_res_ok;
  logic [31:0] a_s_data, a_res_crc;
  logic [3:0]  a_s_keep;
  logic [15:0] a_res_len;

  logic        b_s_valid, b_s_ready, b_s_last, b_res_valid, b_res_ready, b_res_ok;
  logic [7:0]  b_s_data;
  logic [0:0]  b_s_keep;
  logic [31:0] b_res_crc;
  logic [3:0]  b_res_len;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int b_hs   = 0;

  typedef struct {
    int           nbeats;
    logic [127:0] beats;
    logic [3:0]   keep;
    bit           use_model;
    logic [31:0]  crc;
    logic [15:0]  len;
    bit           ok;
  } vec_t;

  vec_t vecs [8];

  crc_stream #(.DATA_W(32), .LEN_W(16)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(a_s_valid), .s_ready_o(a_s_ready), .s_data_i(a_s_data),
    .s_keep_i(a_s_keep), .s_last_i(a_s_last),
    .res_valid_o(a_res_valid), .res_ready_i(a_res_ready),
    .res_crc_o(a_res_crc), .res_len_o(a_res_len), .res_ok_o(a_res_ok)
  );

  crc_stream #(.DATA_W(8), .LEN_W(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(b_s_valid), .s_ready_o(b_s_ready), .s_data_i(b_s_data),
    .s_keep_i(b_s_keep), .s_last_i(b_s_last),
    .res_valid_o(b_res_valid), .res_ready_i(b_res_ready),
    .res_crc_o(b_res_crc), .res_len_o(b_res_len), .res_ok_o(b_res_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts result handshakes on the 8-bit instance; inputs settle at the falling edge.
  always @(negedge clk) begin
    #1;
    if (b_res_valid && b_res_ready) b_hs++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bit-serial LFSR form of reflected CRC-32 with standard init and final XOR.
  function automatic logic [31:0] crc_ref(input logic [7:0] bytes_q[$]);
    logic [31:0] r;
    logic        fb;
    r = 32'hFFFFFFFF;
    foreach (bytes_q[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[0] ^ bytes_q[k][b];
        r  = r >> 1;
        if (fb) r = r ^ 32'hEDB88320;
      end
    end
    return r ^ 32'hFFFFFFFF;
  endfunction

  task automatic send_a(input logic [31:0] d, input logic [3:0] k, input logic l, output int acc_cyc);
    int waited;
    waited    = 0;
    a_s_valid = 1'b1;
    a_s_data  = d;
    a_s_keep  = k;
    a_s_last  = l;
    while (!a_s_ready && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (!a_s_ready) check("a_ready_timeout", {63'd0, a_s_ready}, 64'd1);
    acc_cyc = cyc;
    @(negedge clk);
    a_s_valid = 1'b0;
    a_s_last  = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    int waited;
    waited    = 0;
    b_s_valid = 1'b1;
    b_s_data  = d;
    b_s_keep  = 1'b1;
    b_s_last  = l;
    while (!b_s_ready && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (!b_s_ready) check("b_ready_timeout", {63'd0, b_s_ready}, 64'd1);
    @(negedge clk);
    b_s_valid = 1'b0;
    b_s_last  = 1'b0;
  endtask

  task automatic check_res_a(input string name, input logic [31:0] crc, input logic [15:0] len,
                             input logic ok);
    check({name, "_valid"}, {63'd0, a_res_valid}, 64'd1);
    check({name, "_crc"}, {32'd0, a_res_crc}, {32'd0, crc});
    check({name, "_len"}, {48'd0, a_res_len}, {48'd0, len});
    check({name, "_ok"}, {63'd0, a_res_ok}, {63'd0, ok});
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [31:0] exp_crc;
    logic        exp_ok;
    logic        last;
    int          nby, acc, c1, c2, hs0;

    vecs[0] = '{3, {32'h0, 32'h00000039, 32'h38373635, 32'h34333231}, 4'b0001, 1'b0, 32'hCBF43926, 16'd9, 1'b0};
    vecs[1] = '{1, 128'h0, 4'b0000, 1'b0, 32'h00000000, 16'd0, 1'b0};
    vecs[2] = '{1, {96'h0, 32'h34333231}, 4'b1111, 1'b0, 32'h9BE3E0A3, 16'd4, 1'b0};
    vecs[3] = '{4, {32'h000000CB, 32'hF4392639, 32'h38373635, 32'h34333231}, 4'b0001, 1'b0, 32'h2144DF1C, 16'd13, 1'b1};
    vecs[4] = '{4, {32'h000000CA, 32'hF4392639, 32'h38373635, 32'h34333231}, 4'b0001, 1'b1, 32'h0, 16'd13, 1'b0};
    vecs[5] = '{1, {96'h0, 32'h00003231}, 4'b0011, 1'b1, 32'h0, 16'd2, 1'b0};
    vecs[6] = '{2, {64'h0, 32'h38373635, 32'h34333231}, 4'b1111, 1'b1, 32'h0, 16'd8, 1'b0};
    vecs[7] = '{2, {64'h0, 32'h00373635, 32'h34333231}, 4'b0111, 1'b1, 32'h0, 16'd7, 1'b0};

    rst_n       = 1'b0;
    a_s_valid   = 1'b0; a_s_data = '0; a_s_keep = '0; a_s_last = 1'b0; a_res_ready = 1'b1;
    b_s_valid   = 1'b0; b_s_data = '0; b_s_keep = '0; b_s_last = 1'b0; b_res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_a_valid", {63'd0, a_res_valid}, 64'd0);
    check("rst_a_crc", {32'd0, a_res_crc}, 64'd0);
    check("rst_a_len", {48'd0, a_res_len}, 64'd0);
    check("rst_a_ok", {63'd0, a_res_ok}, 64'd0);
    check("rst_b_valid", {63'd0, b_res_valid}, 64'd0);
    check("rst_a_ready", {63'd0, a_s_ready}, 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      q.delete();
      for (int b = 0; b < vecs[v].nbeats; b++) begin
        last = (b == vecs[v].nbeats - 1);
        nby  = last ? $countones(vecs[v].keep) : 4;
        for (int k = 0; k < nby; k++) q.push_back(vecs[v].beats[32*b + 8*k +: 8]);
        send_a(vecs[v].beats[32*b +: 32], last ? vecs[v].keep : 4'hF, last, acc);
      end
      exp_crc = vecs[v].use_model ? crc_ref(q) : vecs[v].crc;
`ifdef CRC_STREAM_CHECK_EN
      exp_ok = vecs[v].ok;
`else
      exp_ok = 1'b0;
`endif
      check_res_a($sformatf("vec%0d", v), exp_crc, vecs[v].len, exp_ok);
    end

    // Two single-beat packets on consecutive cycles: no bubble between accepts.
    send_a(32'h34333231, 4'hF, 1'b1, c1);
    check_res_a("b2b_first", 32'h9BE3E0A3, 16'd4, 1'b0);
    send_a(32'h34333231, 4'hF, 1'b1, c2);
    check("b2b_gap", 64'(c2), 64'(c1 + 1));
    check_res_a("b2b_second", 32'h9BE3E0A3, 16'd4, 1'b0);

    // Abort mid-packet with reset; the next packet must start from a clean register.
    send_a(32'h34333231, 4'hF, 1'b0, acc);
    rst_n = 1'b0;
    #1;
    check("abort_rst_valid", {63'd0, a_res_valid}, 64'd0);
    check("abort_rst_crc", {32'd0, a_res_crc}, 64'd0);
    check("abort_rst_len", {48'd0, a_res_len}, 64'd0);
    check("abort_rst_ok", {63'd0, a_res_ok}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_a(32'h34333231, 4'hF, 1'b0, acc);
    send_a(32'h38373635, 4'hF, 1'b0, acc);
    send_a(32'h00000039, 4'b0001, 1'b1, acc);
    check_res_a("abort_after", 32'hCBF43926, 16'd9, 1'b0);

    // Byte-wide stream with the result held unconsumed for five cycles.
    for (int i = 1; i <= 8; i++) send_b(8'h30 + 8'(i), 1'b0);
    b_res_ready = 1'b0;
    send_b(8'h39, 1'b1);
    check("stall_valid", {63'd0, b_res_valid}, 64'd1);
    check("stall_crc", {32'd0, b_res_crc}, 64'hCBF43926);
    check("stall_len", {60'd0, b_res_len}, 64'd9);
    for (int i = 0; i < 5; i++) begin
      b_s_valid = 1'b1;
      b_s_data  = 8'hAA;
      b_s_last  = 1'b1;
      #1;
      check($sformatf("stall%0d_ready", i), {63'd0, b_s_ready}, 64'd0);
      check($sformatf("stall%0d_valid", i), {63'd0, b_res_valid}, 64'd1);
      check($sformatf("stall%0d_crc", i), {32'd0, b_res_crc}, 64'hCBF43926);
      check($sformatf("stall%0d_len", i), {60'd0, b_res_len}, 64'd9);
      @(negedge clk);
    end
    b_s_valid   = 1'b0;
    b_s_last    = 1'b0;
    hs0         = b_hs;
    b_res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_consumed_once", 64'(b_hs - hs0), 64'd1);
    check("stall_after_valid", {63'd0, b_res_valid}, 64'd0);

    // 20-byte packet into a 4-bit length counter: length pins at 15.
    q.delete();
    for (int i = 0; i < 20; i++) begin
      q.push_back(8'(i * 37 + 5));
      send_b(8'(i * 37 + 5), i == 19);
    end
    check("sat_valid", {63'd0, b_res_valid}, 64'd1);
    check("sat_crc", {32'd0, b_res_crc}, {32'd0, crc_ref(q)});
    check("sat_len", {60'd0, b_res_len}, 64'd15);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
